pulse_gen_multi: RTL and testbench

PULSE_GEN_MULTI -- requirements
Module: pulse_gen_multi

---
 rtl/pulse_gen_pkg.sv | 14 +
 rtl/pulse_chan.sv | 110 +++++++++++
 rtl/pulse_gen_multi.sv | 52 +++++
 tb/tb_pulse_gen_multi.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared types and reset-default configuration for the multi-channel pulse generator.
package pulse_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_t;

    localparam int   DEF_PERIOD_C  = 4800;
    localparam int   DEF_WIDTH_C   = 1;
    localparam logic DEF_ONESHOT_C = 1'b0;
    localparam int   DEF_BURST_C   = 1;

endpackage

// File: rtl/pulse_chan.sv
// One pulse channel: shadow/active config, period counter and IDLE/RUN sequencing.
//   state   | meaning
//   IDLE    | active config tracks shadow; waits for enable (and trig if oneshot)
//   RUN     | counter cycles 0..period-1, pulse high while counter < width
module pulse_chan
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int BURST_W    = 8,
    parameter int DEF_PERIOD = DEF_PERIOD_C
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_wr,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_width,
    input  logic               cfg_oneshot,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               ch_en,
    input  logic               trig,
    output logic               pulse_out,
    output logic               busy,
    output logic               done
);

    chan_state_t        state;
    logic [CNT_W-1:0]   sh_period, sh_width, act_period, act_width;
    logic [CNT_W-1:0]   cnt, cnt_nxt, tc;
    logic               sh_oneshot, act_oneshot;
    logic [BURST_W-1:0] sh_burst, remaining;
    logic               start, at_tc, last;

    // period 0 shares the terminal count of period 1
    always_comb begin
        tc      = (act_period == '0) ? '0 : act_period - CNT_W'(1);
        cnt_nxt = cnt + CNT_W'(1);
        at_tc   = (cnt == tc);
        last    = act_oneshot && (remaining == BURST_W'(1));
        start   = ch_en && (!act_oneshot || trig);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            remaining   <= BURST_W'(DEF_BURST_C);
            pulse_out   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sh_period   <= CNT_W'(DEF_PERIOD);
            sh_width    <= CNT_W'(DEF_WIDTH_C);
            sh_oneshot  <= DEF_ONESHOT_C;
            sh_burst    <= BURST_W'(DEF_BURST_C);
            act_period  <= CNT_W'(DEF_PERIOD);
            act_width   <= CNT_W'(DEF_WIDTH_C);
            act_oneshot <= DEF_ONESHOT_C;
        end else begin
            done <= 1'b0;
            if (cfg_wr) begin
                sh_period  <= cfg_period;
                sh_width   <= cfg_width;
                sh_oneshot <= cfg_oneshot;
                sh_burst   <= cfg_burst;
            end
            case (state)
                ST_IDLE: begin
                    act_period  <= sh_period;
                    act_width   <= sh_width;
                    act_oneshot <= sh_oneshot;
                    if (start) begin
                        state     <= ST_RUN;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        pulse_out <= (sh_width != '0);
                        remaining <= (sh_burst == '0) ? BURST_W'(1) : sh_burst;
                    end
                end
                ST_RUN: begin
                    if (!ch_en) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        cnt       <= '0;
                        pulse_out <= 1'b0;
                    end else if (at_tc && last) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        cnt       <= '0;
                        pulse_out <= 1'b0;
                        done      <= 1'b1;
                    end else if (at_tc) begin
                        act_period  <= sh_period;
                        act_width   <= sh_width;
                        act_oneshot <= sh_oneshot;
                        cnt         <= '0;
                        pulse_out   <= (sh_width != '0);
                        // saturate so a later switch to oneshot cannot wrap the count
                        if (remaining > BURST_W'(1)) begin
                            remaining <= remaining - BURST_W'(1);
                        end
                    end else begin
                        cnt       <= cnt_nxt;
                        pulse_out <= (cnt_nxt < act_width);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pulse_gen_multi.sv
// Multi-channel pulse generator: decodes configuration writes and instantiates one pulse_chan per channel.
module pulse_gen_multi
    import pulse_gen_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = DEF_PERIOD_C,
    parameter int BURST_W    = 8,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_wr,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_width,
    input  logic               cfg_oneshot,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic [NUM_CH-1:0]  ch_en,
    input  logic [NUM_CH-1:0]  trig,
    output logic [NUM_CH-1:0]  pulse_out,
    output logic [NUM_CH-1:0]  busy,
    output logic [NUM_CH-1:0]  done
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        logic wr_sel;

        // addresses at or beyond NUM_CH match no channel and are dropped
        assign wr_sel = cfg_wr && (cfg_ch == CH_W'(i));

        pulse_chan #(
            .CNT_W      (CNT_W),
            .BURST_W    (BURST_W),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .cfg_wr      (wr_sel),
            .cfg_period  (cfg_period),
            .cfg_width   (cfg_width),
            .cfg_oneshot (cfg_oneshot),
            .cfg_burst   (cfg_burst),
            .ch_en       (ch_en[i]),
            .trig        (trig[i]),
            .pulse_out   (pulse_out[i]),
            .busy        (busy[i]),
            .done        (done[i])
        );
    end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Self-checking bench for pulse_gen_multi: directed scenarios plus randomized run against a behavioural model.
module tb_pulse_gen_multi;

    localparam int NCH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            cfg_wr = 1'b0;
    logic [1:0]      cfg_ch = '0;
    logic [15:0]     cfg_period = '0;
    logic [15:0]     cfg_width = '0;
    logic            cfg_oneshot = 1'b0;
    logic [7:0]      cfg_burst = '0;
    logic [NCH-1:0]  ch_en = '0;
    logic [NCH-1:0]  trig = '0;
    logic [NCH-1:0]  pulse_out, busy, done;

    int errors = 0;
    int checks = 0;

    // behavioural model: per-channel position inside the current period
    int m_sp[NCH], m_sw[NCH], m_so[NCH], m_sb[NCH];
    int m_ap[NCH], m_aw[NCH], m_ao[NCH];
    int m_run[NCH], m_pos[NCH], m_left[NCH], m_done[NCH];

    pulse_gen_multi dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_width   (cfg_width),
        .cfg_oneshot (cfg_oneshot),
        .cfg_burst   (cfg_burst),
        .ch_en       (ch_en),
        .trig        (trig),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_sp[c] = 4800; m_sw[c] = 1; m_so[c] = 0; m_sb[c] = 1;
            m_ap[c] = 4800; m_aw[c] = 1; m_ao[c] = 0;
            m_run[c] = 0; m_pos[c] = 0; m_left[c] = 0; m_done[c] = 0;
        end
    endtask

    // advances the model by one clock using the inputs held during that cycle
    task automatic model_step();
        int plen;
        for (int c = 0; c < NCH; c++) begin
            m_done[c] = 0;
            plen = (m_ap[c] == 0) ? 1 : m_ap[c];
            if (m_run[c] == 0) begin
                if (ch_en[c] && (m_ao[c] == 0 || trig[c])) begin
                    m_run[c]  = 1;
                    m_pos[c]  = 0;
                    m_left[c] = (m_sb[c] == 0) ? 1 : m_sb[c];
                end
                m_ap[c] = m_sp[c]; m_aw[c] = m_sw[c]; m_ao[c] = m_so[c];
            end else if (!ch_en[c]) begin
                m_run[c] = 0;
            end else if (m_pos[c] == plen - 1) begin
                if (m_ao[c] != 0 && m_left[c] == 1) begin
                    m_run[c]  = 0;
                    m_done[c] = 1;
                end else begin
                    m_pos[c] = 0;
                    if (m_left[c] > 1) m_left[c] = m_left[c] - 1;
                    m_ap[c] = m_sp[c]; m_aw[c] = m_sw[c]; m_ao[c] = m_so[c];
                end
            end else begin
                m_pos[c] = m_pos[c] + 1;
            end
            if (cfg_wr && int'(cfg_ch) == c) begin
                m_sp[c] = int'(cfg_period); m_sw[c] = int'(cfg_width);
                m_so[c] = int'(cfg_oneshot); m_sb[c] = int'(cfg_burst);
            end
        end
    endtask

    function automatic logic [NCH-1:0] exp_pulse();
        logic [NCH-1:0] e;
        for (int c = 0; c < NCH; c++) e[c] = (m_run[c] != 0) && (m_pos[c] < m_aw[c]);
        return e;
    endfunction

    function automatic logic [NCH-1:0] exp_busy();
        logic [NCH-1:0] e;
        for (int c = 0; c < NCH; c++) e[c] = (m_run[c] != 0);
        return e;
    endfunction

    function automatic logic [NCH-1:0] exp_done();
        logic [NCH-1:0] e;
        for (int c = 0; c < NCH; c++) e[c] = (m_done[c] != 0);
        return e;
    endfunction

    task automatic wr_cfg(input int ch, input int p, input int w, input int o, input int b);
        cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_period = 16'(p);
        cfg_width = 16'(w); cfg_oneshot = 1'(o); cfg_burst = 8'(b);
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic test_reset();
        ch_en = '1;
        repeat (2) @(negedge clk);
        checks++;
        if ({pulse_out, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%b/%b expected all zero", pulse_out, busy, done);
        end
        ch_en = '0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== '0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b expected 0000", busy);
        end
    endtask

    task automatic test_default();
        int k;
        ch_en[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (pulse_out !== 4'b0001 || busy !== 4'b0001) begin
            errors++;
            $display("FAIL default_first_rise: got pulse %b busy %b expected 0001/0001", pulse_out, busy);
        end
        @(negedge clk);
        checks++;
        if (pulse_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL default_width: got %b expected 0", pulse_out[0]);
        end
        k = 1;
        while (pulse_out[0] !== 1'b1 && k < 6000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != 4800) begin
            errors++;
            $display("FAIL default_period: got %0d cycles expected 4800", k);
        end
        ch_en[0] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_continuous();
        logic [NCH-1:0] e;
        wr_cfg(1, 10, 3, 0, 1);
        @(negedge clk);
        ch_en[1] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            e = '0;
            e[1] = ((i % 10) < 3);
            checks++;
            if (pulse_out !== e) begin
                errors++;
                $display("FAIL cont_pattern[%0d]: got %b expected %b", i, pulse_out, e);
            end
            @(negedge clk);
        end
        ch_en[1] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_burst();
        logic [2:0] obs, req;
        wr_cfg(2, 5, 2, 1, 3);
        @(negedge clk);
        ch_en[2] = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL burst_wait_trig: got busy %b expected 0", busy[2]);
        end
        trig[2] = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            trig[2] = (i == 4);
            obs = {pulse_out[2], busy[2], done[2]};
            if (i <= 15) req = {(((i - 1) % 5) < 2), 1'b1, 1'b0};
            else if (i == 16) req = 3'b001;
            else req = 3'b000;
            checks++;
            if (obs !== req) begin
                errors++;
                $display("FAIL burst_cycle[%0d]: got pulse/busy/done %b expected %b", i, obs, req);
            end
        end
        ch_en[2] = 1'b0;
        @(negedge clk);
        trig[2] = 1'b1;
        @(negedge clk);
        trig[2] = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL burst_trig_disabled: got busy %b expected 0", busy[2]);
        end
    endtask

    task automatic test_cfg_midperiod();
        logic req;
        wr_cfg(0, 8, 1, 0, 1);
        @(negedge clk);
        ch_en[0] = 1'b1;
        @(negedge clk);
        for (int i = 0; i <= 40; i++) begin
            req = (i == 0 || i == 8 || i == 28);
            checks++;
            if (pulse_out[0] !== req) begin
                errors++;
                $display("FAIL cfg_midperiod[%0d]: got %b expected %b", i, pulse_out[0], req);
            end
            if (i == 3) begin
                cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_period = 16'd20;
                cfg_width = 16'd1; cfg_oneshot = 1'b0; cfg_burst = 8'd1;
            end else begin
                cfg_wr = 1'b0;
            end
            @(negedge clk);
        end
        ch_en[0] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_disable();
        ch_en[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pulse_out[1] !== 1'b1) begin
            errors++;
            $display("FAIL disable_pre: got %b expected 1", pulse_out[1]);
        end
        ch_en[1] = 1'b0;
        @(negedge clk);
        checks++;
        if ({pulse_out[1], busy[1], done[1]} !== 3'b000) begin
            errors++;
            $display("FAIL disable_drop: got %b expected 000", {pulse_out[1], busy[1], done[1]});
        end
        @(negedge clk);
        checks++;
        if (done[1] !== 1'b0) begin
            errors++;
            $display("FAIL disable_no_done: got %b expected 0", done[1]);
        end
    endtask

    task automatic test_reset_midrun();
        int k;
        ch_en = 4'b0011;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({pulse_out, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_async: got %b/%b/%b expected all zero", pulse_out, busy, done);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (pulse_out !== 4'b0011) begin
            errors++;
            $display("FAIL reset_restart: got %b expected 0011", pulse_out);
        end
        @(negedge clk);
        checks++;
        if (pulse_out !== 4'b0000) begin
            errors++;
            $display("FAIL reset_default_width: got %b expected 0000", pulse_out);
        end
        k = 1;
        while (pulse_out[1] !== 1'b1 && k < 6000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != 4800) begin
            errors++;
            $display("FAIL reset_default_period: got %0d cycles expected 4800", k);
        end
        ch_en = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        ch_en = 4'($urandom);
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            model_step();
            checks++;
            if (pulse_out !== exp_pulse()) begin
                errors++;
                $display("FAIL rand_pulse[%0d]: got %b expected %b", n, pulse_out, exp_pulse());
            end
            checks++;
            if (busy !== exp_busy()) begin
                errors++;
                $display("FAIL rand_busy[%0d]: got %b expected %b", n, busy, exp_busy());
            end
            checks++;
            if (done !== exp_done()) begin
                errors++;
                $display("FAIL rand_done[%0d]: got %b expected %b", n, done, exp_done());
            end
            cfg_wr = ($urandom_range(0, 5) == 0);
            cfg_ch = 2'($urandom);
            cfg_period = 16'($urandom_range(0, 12));
            cfg_width = 16'($urandom_range(0, 14));
            cfg_oneshot = 1'($urandom);
            cfg_burst = 8'($urandom_range(0, 4));
            trig = 4'($urandom) & 4'($urandom);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 29) == 0) ch_en[c] = ~ch_en[c];
            end
        end
        cfg_wr = 1'b0;
        trig = '0;
        ch_en = '0;
    endtask

    initial begin
        test_reset();
        test_default();
        test_continuous();
        test_burst();
        test_cfg_midperiod();
        test_disable();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
